// File: rtl/alu.sv
// rtl/alu.sv - registered integer ALU (add/sub, logic, LUI, shifts); SLT/SLTU enabled by ALU_SLT_EN
// Result and zero flag are computed from one next-state value so they can never disagree.
module alu #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        kontrol,
    output logic [DATA_W-1:0] c,
    output logic              z_flag
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_LUI  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1111;
`ifdef ALU_SLT_EN
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
`endif

    logic [SH_W-1:0]   sh_amt;
    logic [DATA_W-1:0] c_d, c_q;
    logic              z_d, z_q;

    // Upper bits of a are deliberately ignored for shift amounts.
    assign sh_amt = a[SH_W-1:0];

    always_comb begin
        c_d = '0;
        case (kontrol)
            OP_ADD:  c_d = a + b;
            OP_SUB:  c_d = a - b;
            OP_AND:  c_d = a & b;
            OP_OR:   c_d = a | b;
            OP_XOR:  c_d = a ^ b;
            OP_LUI:  c_d = b;
            OP_SLL:  c_d = b << sh_amt;
            OP_SRL:  c_d = b >> sh_amt;
            OP_SRA:  c_d = $unsigned($signed(b) >>> sh_amt);
`ifdef ALU_SLT_EN
            OP_SLT:  c_d = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: c_d = {{(DATA_W-1){1'b0}}, (a < b)};
`endif
            default: c_d = '0;
        endcase
        z_d = (c_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
            z_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
        end
    end

    assign c      = c_q;
    assign z_flag = z_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - vector table plus scoreboard bench for alu; SLT expectations follow ALU_SLT_EN
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  kontrol;
    logic [31:0] c;
    logic        z_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  k;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_c;
        logic        exp_z;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp_c;
        logic        exp_z;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    alu #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .kontrol (kontrol),
        .c       (c),
        .z_flag  (z_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic [3:0] k, logic [31:0] va, logic [31:0] vb,
                                logic [31:0] ec, logic ez);
        vec_t v;
        v.name = n; v.k = k; v.a = va; v.b = vb; v.exp_c = ec; v.exp_z = ez;
        return v;
    endfunction

    // Independent reference: subtraction via two's complement, shifts bit by bit.
    function automatic logic [31:0] model(logic [3:0] k, logic [31:0] va, logic [31:0] vb);
        logic [31:0] r;
        int          s;
        s = int'(va[4:0]);
        r = 32'h0;
        case (k)
            4'b0000: r = va + vb;
            4'b0100: r = va + (~vb) + 32'd1;
            4'b0001: r = va & vb;
            4'b0101: r = va | vb;
            4'b0010: r = va ^ vb;
            4'b0110: r = vb;
            4'b0011: for (int i = 0; i < 32; i++) r[i] = (i >= s) ? vb[i-s] : 1'b0;
            4'b0111: for (int i = 0; i < 32; i++) r[i] = (i + s <= 31) ? vb[i+s] : 1'b0;
            4'b1111: for (int i = 0; i < 32; i++) r[i] = (i + s <= 31) ? vb[i+s] : vb[31];
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic check(string n, logic [31:0] ec, logic ez);
        checks++;
        if (c !== ec) begin
            errors++;
            $display("FAIL %s: c=%h expected %h", n, c, ec);
        end
        checks++;
        if (z_flag !== ez) begin
            errors++;
            $display("FAIL %s: z_flag=%b expected %b", n, z_flag, ez);
        end
    endtask

    task automatic check_pending();
        sb_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check(e.name, e.exp_c, e.exp_z);
    endtask

    task automatic push(string n, logic [31:0] ec, logic ez);
        sb_t e;
        e.name = n; e.exp_c = ec; e.exp_z = ez;
        sb.push_back(e);
    endtask

    // Results of the previous issue are checked on the same negedge the next op is driven.
    task automatic issue(string n, logic [3:0] k, logic [31:0] va, logic [31:0] vb,
                         logic [31:0] ec, logic ez);
        @(negedge clk);
        check_pending();
        kontrol = k; a = va; b = vb;
        push(n, ec, ez);
    endtask

    task automatic drain();
        @(negedge clk);
        check_pending();
    endtask

    initial begin
        logic [31:0] ra, rb, rc;
        logic [3:0]  rk;
        logic [3:0]  ops[9];
        ops = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0110, 4'b0011, 4'b0111, 4'b1111};

        vecs.push_back(mk("add_2_1",    4'b0000, 32'h2,        32'h1,        32'h3,        1'b0));
        vecs.push_back(mk("sub_2_1",    4'b0100, 32'h2,        32'h1,        32'h1,        1'b0));
        vecs.push_back(mk("sub_ff_ff",  4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1));
        vecs.push_back(mk("add_ff_ff",  4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0));
        vecs.push_back(mk("and",        4'b0001, 32'hCCCCCCCC, 32'hAAAAAAAA, 32'h88888888, 1'b0));
        vecs.push_back(mk("or",         4'b0101, 32'hCCCCCCCC, 32'hAAAAAAAA, 32'hEEEEEEEE, 1'b0));
        vecs.push_back(mk("xor",        4'b0010, 32'h33333333, 32'hFF005555, 32'hCC336666, 1'b0));
        vecs.push_back(mk("lui",        4'b0110, 32'h33333333, 32'hFF005555, 32'hFF005555, 1'b0));
        vecs.push_back(mk("sll_15",     4'b0011, 32'h0000000F, 32'hFFFFFFFF, 32'hFFFF8000, 1'b0));
        vecs.push_back(mk("srl_15",     4'b0111, 32'h0000000F, 32'hFFFFFFFF, 32'h0001FFFF, 1'b0));
        vecs.push_back(mk("sra_pos",    4'b1111, 32'h00000010, 32'h7F000000, 32'h00007F00, 1'b0));
        vecs.push_back(mk("sra_neg",    4'b1111, 32'h00000010, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk("sll_hi_ign", 4'b0011, 32'hFFFFFFE4, 32'h00000001, 32'h00000010, 1'b0));
        vecs.push_back(mk("sra_by_0",   4'b1111, 32'h00000020, 32'h80000001, 32'h80000001, 1'b0));
        vecs.push_back(mk("srl_31",     4'b0111, 32'h0000001F, 32'h80000000, 32'h00000001, 1'b0));
        vecs.push_back(mk("undef_1010", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1));
        vecs.push_back(mk("undef_1100", 4'b1100, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b1));
        vecs.push_back(mk("undef_1110", 4'b1110, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b1));
`ifdef ALU_SLT_EN
        vecs.push_back(mk("slt",        4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h1,        1'b0));
        vecs.push_back(mk("sltu",       4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b1));
        vecs.push_back(mk("sltu_lt",    4'b1001, 32'h00000001, 32'hFFFFFFFF, 32'h1,        1'b0));
`else
        vecs.push_back(mk("slt_off",    4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b1));
        vecs.push_back(mk("sltu_off",   4'b1001, 32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b1));
`endif

        rst_n = 1'b0; a = 32'h0; b = 32'h0; kontrol = 4'b0000;
        #1;
        check("reset_state", 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            issue(vecs[i].name, vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].exp_c, vecs[i].exp_z);
        drain();

        for (int i = 0; i < 40; i++) begin
            ra = $urandom();
            rb = $urandom();
            rk = ops[$urandom_range(0, 8)];
            rc = model(rk, ra, rb);
            issue($sformatf("rand_%0d_k%b", i, rk), rk, ra, rb, rc, rc == 32'h0);
        end
        drain();

        // Asynchronous reset mid-cycle with a nonzero result held.
        issue("pre_reset_add", 4'b0000, 32'h2, 32'h1, 32'h3, 1'b0);
        @(posedge clk);
        #1;
        check_pending();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 32'h0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        kontrol = 4'b0000; a = 32'h5; b = 32'h7;
        push("first_after_reset", 32'hC, 1'b0);
        issue("sub_after_reset", 4'b0100, 32'h7, 32'h7, 32'h0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
